prio_scan_isolate: RTL and testbench

//  Parametrised, sequential successor to our fixed 32-bit first-set-bit isolator.
//  - Accepts a WIDTH-bit vector over a valid/ready handshake.
//  - Scans it CHUNK bits per cycle, from the LSB or MSB end (selected per transaction).
//  - Returns the one-hot isolate of the winning set bit, its binary index and a found flag.
//  - Sits between operand staging and the downstream select/encode stage in the FHE datapath.

---
 rtl/prio_scan_pkg.sv | 30 +++
 rtl/prio_chunk_isolate.sv | 33 +++
 rtl/prio_scan_isolate.sv | 129 ++++++++++++
 tb/tb_prio_scan_isolate.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/prio_scan_pkg.sv
// Shared types and elaboration helpers for the chunked first-set-bit isolator.
// The top level derives its chunk count and counter width from these helpers.
package prio_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Counter/index widths never collapse to zero bits when there is only one position.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit chunk_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

  localparam int DEF_NCHUNK = nchunk(DEF_WIDTH, DEF_CHUNK);
  localparam int DEF_KW     = cnt_width(DEF_NCHUNK);

endpackage

// File: rtl/prio_chunk_isolate.sv
// Combinational isolate of one chunk: keeps the lowest (or highest) set bit and
// reports its position within the chunk.
module prio_chunk_isolate
  import prio_scan_pkg::*;
#(
  parameter  int CHUNK = DEF_CHUNK,
  localparam int LIDXW = cnt_width(CHUNK)
) (
  input  logic [CHUNK-1:0] chunk,
  input  logic             msb_first,
  output logic [CHUNK-1:0] onehot,
  output logic [LIDXW-1:0] local_idx,
  output logic             any
);

  // The loop direction decides which set bit is written last and therefore wins.
  always_comb begin
    local_idx = '0;
    onehot    = '0;
    any       = |chunk;
    if (msb_first) begin
      for (int i = 0; i < CHUNK; i++) begin
        if (chunk[i]) local_idx = LIDXW'(i);
      end
    end else begin
      for (int i = CHUNK - 1; i >= 0; i--) begin
        if (chunk[i]) local_idx = LIDXW'(i);
      end
    end
    if (any) onehot[local_idx] = 1'b1;
  end

endmodule

// File: rtl/prio_scan_isolate.sv
// Sequential first-set-bit isolator: scans a WIDTH-bit vector CHUNK bits per cycle
// from either end and returns the one-hot winner, its index and a found flag.
module prio_scan_isolate
  import prio_scan_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int CHUNK = DEF_CHUNK,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [IDXW-1:0]  out_index,
  output logic             out_found
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int KW     = cnt_width(NCHUNK);
  localparam int LIDXW  = cnt_width(CHUNK);
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_chunk
    $error("prio_scan_isolate: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t state, state_nxt;

  logic [WIDTH-1:0] vec_q;
  logic             msb_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] onehot_q;
  logic [IDXW-1:0]  index_q;
  logic             found_q;

  logic             accept;
  logic [IDXW-1:0]  base;
  logic [CHUNK-1:0] chunk;
  logic [CHUNK-1:0] ch_onehot;
  logic [LIDXW-1:0] ch_idx;
  logic             ch_any;
  logic [WIDTH-1:0] win_onehot;
  logic [IDXW-1:0]  win_idx;

  assign accept = in_valid & in_ready;

  // MSB mode walks chunks downward from the top, so chunk k starts at WIDTH-(k+1)*CHUNK.
  always_comb begin
    if (msb_q) base = IDXW'(WIDTH - (int'(k_q) + 1) * CHUNK);
    else       base = IDXW'(int'(k_q) * CHUNK);
    chunk      = vec_q[base +: CHUNK];
    win_idx    = base + IDXW'(ch_idx);
    win_onehot = WIDTH'(ch_onehot) << base;
  end

  prio_chunk_isolate #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .chunk     (chunk),
    .msb_first (msb_q),
    .onehot    (ch_onehot),
    .local_idx (ch_idx),
    .any       (ch_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A zero vector has no winner to search for, so it bypasses SCAN entirely.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = (in_vec == '0) ? DONE : SCAN;
      SCAN: if (ch_any) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Results are cleared on acceptance so a zero vector reports found=0 with no extra logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q    <= '0;
      msb_q    <= 1'b0;
      k_q      <= '0;
      onehot_q <= '0;
      index_q  <= '0;
      found_q  <= 1'b0;
    end else if (accept) begin
      vec_q    <= in_vec;
      msb_q    <= in_msb_first;
      k_q      <= '0;
      onehot_q <= '0;
      index_q  <= '0;
      found_q  <= 1'b0;
    end else if (state == SCAN) begin
      if (ch_any) begin
        onehot_q <= win_onehot;
        index_q  <= win_idx;
        found_q  <= 1'b1;
      end else if (k_q != KLAST) begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  assign out_onehot = onehot_q;
  assign out_index  = index_q;
  assign out_found  = found_q;

  // A non-zero captured vector must hit by the last chunk; a miss there means corrupted state.
  a_no_last_miss: assert property (@(posedge clk) disable iff (!rst_n)
    !((state == SCAN) && (k_q == KLAST) && !ch_any));

  a_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(onehot_q));

endmodule

// File: tb/tb_prio_scan_isolate.sv
// Directed self-checking bench for prio_scan_isolate (WIDTH=32, CHUNK=8) with
// hand-computed winners and latencies.
module tb_prio_scan_isolate;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_vec;
  logic        in_msb_first;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_onehot;
  logic [4:0]  out_index;
  logic        out_found;

  int total = 0;
  int bad   = 0;

  prio_scan_isolate #(
    .WIDTH (32),
    .CHUNK (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_vec       (in_vec),
    .in_msb_first (in_msb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_onehot   (out_onehot),
    .out_index    (out_index),
    .out_found    (out_found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: present at a negedge, measure cycles to out_valid, check, drain.
  task automatic applyStimulus(input string tag, input logic [31:0] vec, input logic msb,
                               input logic [31:0] eoh, input logic [31:0] eidx,
                               input logic efound, input int elat);
    int lat;
    @(negedge clk);
    checkOutput({tag, " in_ready before"}, 32'(in_ready), 32'd1);
    in_valid     = 1'b1;
    in_vec       = vec;
    in_msb_first = msb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_vec   = 32'hDEAD_BEEF;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 32'(lat), 32'(elat));
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, " onehot"}, out_onehot, eoh);
    checkOutput({tag, " index"}, 32'(out_index), eidx);
    checkOutput({tag, " found"}, 32'(out_found), 32'(efound));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, " drained out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, " drained in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_vec       = '0;
    in_msb_first = 1'b0;
    out_ready    = 1'b0;
    #2;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset onehot", out_onehot, 32'd0);
    checkOutput("reset index", 32'(out_index), 32'd0);
    checkOutput("reset found", 32'(out_found), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("t1 lsb bit0", 32'h0000_0001, 1'b0, 32'h0000_0001, 32'd0, 1'b1, 2);
    applyStimulus("t2 lsb bit31", 32'h8000_0000, 1'b0, 32'h8000_0000, 32'd31, 1'b1, 5);
    applyStimulus("t3 msb ends", 32'h8000_0001, 1'b1, 32'h8000_0000, 32'd31, 1'b1, 2);
    applyStimulus("t3 lsb ends", 32'h8000_0001, 1'b0, 32'h0000_0001, 32'd0, 1'b1, 2);
    applyStimulus("t4 zero", 32'h0000_0000, 1'b0, 32'h0000_0000, 32'd0, 1'b0, 1);
    applyStimulus("t4 zero msb", 32'h0000_0000, 1'b1, 32'h0000_0000, 32'd0, 1'b0, 1);
    applyStimulus("msb bit0", 32'h0000_0001, 1'b1, 32'h0000_0001, 32'd0, 1'b1, 5);
    applyStimulus("lsb nibble", 32'h00F0_0000, 1'b0, 32'h0010_0000, 32'd20, 1'b1, 4);
    applyStimulus("msb nibble", 32'h00F0_0000, 1'b1, 32'h0080_0000, 32'd23, 1'b1, 3);
    applyStimulus("lsb mixed", 32'h1234_5600, 1'b0, 32'h0000_0200, 32'd9, 1'b1, 3);

    // Stall in DONE with junk pulses on in_valid, then release with a new vector waiting.
    $display("[TB] stall and back-to-back handshake");
    @(negedge clk);
    in_valid     = 1'b1;
    in_vec       = 32'h0000_0300;
    in_msb_first = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t5 valid at 3", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid     = (i % 2) == 0;
      in_vec       = 32'hFFFF_FFFF;
      in_msb_first = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("t5 stall out_valid", 32'(out_valid), 32'd1);
      checkOutput("t5 stall onehot", out_onehot, 32'h0000_0100);
      checkOutput("t5 stall index", 32'(out_index), 32'd8);
      checkOutput("t5 stall in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid     = 1'b1;
    in_vec       = 32'h0000_0010;
    in_msb_first = 1'b1;
    out_ready    = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("t5 release out_valid", 32'(out_valid), 32'd0);
    checkOutput("t5 release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("t5 accepted in_ready", 32'(in_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t5 next out_valid", 32'(out_valid), 32'd1);
    checkOutput("t5 next onehot", out_onehot, 32'h0000_0010);
    checkOutput("t5 next index", 32'(out_index), 32'd4);
    checkOutput("t5 next found", 32'(out_found), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Asynchronous reset while the scan is still walking toward chunk 3.
    $display("[TB] reset mid-scan");
    @(negedge clk);
    in_valid     = 1'b1;
    in_vec       = 32'h0100_0000;
    in_msb_first = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("t6 rst onehot", out_onehot, 32'd0);
    checkOutput("t6 rst index", 32'(out_index), 32'd0);
    checkOutput("t6 rst found", 32'(out_found), 32'd0);
    checkOutput("t6 rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkOutput("t6 no stale valid", 32'(out_valid), 32'd0);
      checkOutput("t6 idle in_ready", 32'(in_ready), 32'd1);
    end
    applyStimulus("t6 recover", 32'h0000_0080, 1'b0, 32'h0000_0080, 32'd7, 1'b1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
